// File: rtl/host_vram_ctrl.sv
// host_vram_ctrl: host-side command sequencer between spi_target and the memories.
// Turns the SPI byte stream into VRAM read/write and font RAM write transactions.
// VRAM is only driven inside blitter slots (blit_cycle_i); the font port is free-running.
// Optional feature macro: HOST_CTRL_STATUS_EN (op 2'b11 becomes a status read that
// also clears the sticky overrun flag); without it op 2'b11 is a NOP.
//
// state   | meaning
// CMD     | waiting for command byte
// ADDR_H  | next byte loads addr[15:8]
// ADDR_L  | next byte loads addr[7:0]
// DATA_H  | next byte is VRAM high byte / font data byte
// DATA_L  | next byte is VRAM low byte / font data byte
module host_vram_ctrl #(
  parameter int VRAM_AW = 16,
  parameter int FONT_AW = 13
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               spi_cs_i,
  input  logic               rx_strobe_i,
  input  logic [7:0]         rx_byte_i,
  output logic [7:0]         tx_byte_o,
  input  logic               blit_cycle_i,
  output logic               vram_sel_o,
  output logic               vram_wr_o,
  output logic [VRAM_AW-1:0] vram_addr_o,
  output logic [15:0]        vram_data_o,
  input  logic [15:0]        vram_data_i,
  output logic               font_wr_o,
  output logic [FONT_AW-1:0] font_addr_o,
  output logic [7:0]         font_data_o,
  output logic               busy_o,
  output logic               err_o
);

  localparam logic [2:0] ST_CMD    = 3'd0;
  localparam logic [2:0] ST_ADDR_H = 3'd1;
  localparam logic [2:0] ST_ADDR_L = 3'd2;
  localparam logic [2:0] ST_DATA_H = 3'd3;
  localparam logic [2:0] ST_DATA_L = 3'd4;

  localparam logic [1:0] OP_VWR = 2'b00;
  localparam logic [1:0] OP_VRD = 2'b01;
  localparam logic [1:0] OP_FWR = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  logic [2:0]         state;
  logic [1:0]         op;
  logic               auto_inc;
  logic [15:0]        addr;
  logic [15:0]        addr_inc;
  logic [7:0]         hi_byte;
  logic               wr_pend;
  logic [15:0]        wr_addr;
  logic [15:0]        wr_word;
  logic               rd_pend;
  logic               rd_wait;
  logic [15:0]        rd_word;
  logic               err;
  logic               font_wr_q;
  logic [FONT_AW-1:0] font_addr_q;
  logic [7:0]         font_data_q;
  logic               stat_mode;
  logic               issue_wr;
  logic               issue_rd;
  logic [15:0]        sel_addr;

  assign addr_inc = addr + 16'd1;
  // a pending write owns the slot first; a read only goes when no write is waiting
  assign issue_wr = blit_cycle_i & wr_pend;
  assign issue_rd = blit_cycle_i & rd_pend & ~wr_pend;
  assign sel_addr = wr_pend ? wr_addr : addr;

  // VRAM strobes are combinational so they can never leak outside a blitter slot or into reset
  assign vram_sel_o  = ~reset & (issue_wr | issue_rd);
  assign vram_wr_o   = ~reset & issue_wr;
  assign vram_addr_o = vram_sel_o ? sel_addr[VRAM_AW-1:0] : '0;
  assign vram_data_o = vram_wr_o ? wr_word : 16'h0000;
  assign busy_o      = ~reset & (wr_pend | rd_pend);
  assign err_o       = ~reset & err;
  assign font_wr_o   = ~reset & font_wr_q;
  assign font_addr_o = font_addr_q;
  assign font_data_o = font_data_q;

  // command parsing, pending VRAM entries, read capture and font write strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_CMD;
      op          <= OP_VWR;
      auto_inc    <= 1'b0;
      addr        <= 16'h0000;
      hi_byte     <= 8'h00;
      wr_pend     <= 1'b0;
      wr_addr     <= 16'h0000;
      wr_word     <= 16'h0000;
      rd_pend     <= 1'b0;
      rd_wait     <= 1'b0;
      rd_word     <= 16'h0000;
      err         <= 1'b0;
      font_wr_q   <= 1'b0;
      font_addr_q <= '0;
      font_data_q <= 8'h00;
    end else begin
      font_wr_q <= 1'b0;
      if (issue_wr) begin
        wr_pend <= 1'b0;
        if (auto_inc) addr <= addr_inc;
      end
      if (issue_rd) begin
        rd_pend <= 1'b0;
        rd_wait <= 1'b1;
      end
      if (rd_wait) begin
        rd_wait <= 1'b0;
        rd_word <= vram_data_i;
        if (auto_inc) addr <= addr_inc;
      end
      if (spi_cs_i) begin
        state <= ST_CMD;
      end else if (rx_strobe_i) begin
        case (state)
          ST_CMD: begin
            op       <= rx_byte_i[7:6];
            auto_inc <= rx_byte_i[0];
            if (rx_byte_i[7:6] != OP_RSV) state <= ST_ADDR_H;
`ifdef HOST_CTRL_STATUS_EN
            if (stat_mode) err <= 1'b0;
`endif
          end
          ST_ADDR_H: begin
            addr  <= {rx_byte_i, addr[7:0]};
            state <= ST_ADDR_L;
          end
          ST_ADDR_L: begin
            addr  <= {addr[15:8], rx_byte_i};
            state <= ST_DATA_H;
            if (op == OP_VRD) rd_pend <= 1'b1;
          end
          ST_DATA_H: begin
            state <= ST_DATA_L;
            if (op == OP_VWR) hi_byte <= rx_byte_i;
          end
          ST_DATA_L: begin
            state <= ST_DATA_H;
            if (op == OP_VWR) begin
              // the slot issuing the old entry this cycle frees room for the new word
              if (wr_pend && !issue_wr) begin
                err <= 1'b1;
              end else begin
                wr_pend <= 1'b1;
                wr_word <= {hi_byte, rx_byte_i};
                wr_addr <= (issue_wr && auto_inc) ? addr_inc : addr;
              end
            end else if (op == OP_VRD && !rd_pend && !rd_wait) begin
              rd_pend <= 1'b1;
            end
          end
          default: state <= ST_CMD;
        endcase
        if (op == OP_FWR && (state == ST_DATA_H || state == ST_DATA_L)) begin
          font_wr_q   <= 1'b1;
          font_addr_q <= addr[FONT_AW-1:0];
          font_data_q <= rx_byte_i;
          if (auto_inc) addr <= addr_inc;
        end
      end
    end
  end

`ifdef HOST_CTRL_STATUS_EN
  // status byte is presented for the one byte following an op 2'b11 command
  always_ff @(posedge clk) begin
    if (reset || spi_cs_i) stat_mode <= 1'b0;
    else if (rx_strobe_i && state == ST_CMD) stat_mode <= (rx_byte_i[7:6] == OP_RSV);
  end
`else
  assign stat_mode = 1'b0;
`endif

  // next byte to shift out: read data once it has landed, 8'hFF otherwise
  always_comb begin
    tx_byte_o = 8'hFF;
    if (reset) begin
      tx_byte_o = 8'hFF;
    end else if (stat_mode) begin
      tx_byte_o = {6'b000000, wr_pend | rd_pend, err};
    end else if (op == OP_VRD && !rd_pend && !rd_wait) begin
      if (state == ST_DATA_H) tx_byte_o = rd_word[15:8];
      else if (state == ST_DATA_L) tx_byte_o = rd_word[7:0];
    end
  end

endmodule

// File: tb/tb_host_vram_ctrl.sv
// Self-checking bench for host_vram_ctrl: directed scenarios followed by randomized
// write/read/font streams checked against a transaction-level memory/log model.
`timescale 1ns/1ps
module tb_host_vram_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        spi_cs_i;
  logic        rx_strobe_i;
  logic [7:0]  rx_byte_i;
  logic [7:0]  tx_byte_o;
  logic        blit_cycle_i;
  logic        blit_man;
  logic        blit_rnd_en;
  logic        rnd_bit = 1'b0;
  logic        vram_sel_o;
  logic        vram_wr_o;
  logic [15:0] vram_addr_o;
  logic [15:0] vram_data_o;
  logic [15:0] vram_data_i = 16'h0000;
  logic        font_wr_o;
  logic [12:0] font_addr_o;
  logic [7:0]  font_data_o;
  logic        busy_o;
  logic        err_o;

  int tests = 0;
  int fails = 0;
  logic bad_sel = 1'b0;
  logic [15:0] mem [0:65535];
  logic [31:0] vwr_q[$];
  logic [15:0] vrd_q[$];
  logic [12:0] fadr_q[$];
  logic [7:0]  fdat_q[$];

  assign blit_cycle_i = blit_man | (blit_rnd_en & rnd_bit);

  always #5 clk = ~clk;

  host_vram_ctrl dut (
    .clk(clk), .reset(reset), .spi_cs_i(spi_cs_i), .rx_strobe_i(rx_strobe_i),
    .rx_byte_i(rx_byte_i), .tx_byte_o(tx_byte_o), .blit_cycle_i(blit_cycle_i),
    .vram_sel_o(vram_sel_o), .vram_wr_o(vram_wr_o), .vram_addr_o(vram_addr_o),
    .vram_data_o(vram_data_o), .vram_data_i(vram_data_i), .font_wr_o(font_wr_o),
    .font_addr_o(font_addr_o), .font_data_o(font_data_o), .busy_o(busy_o), .err_o(err_o)
  );

  // random slot pattern
  always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));

  // VRAM read port: data valid one cycle after a read select
  always @(posedge clk) if (vram_sel_o && !vram_wr_o) vram_data_i <= mem[vram_addr_o];

  // transaction logs, sampled mid-cycle
  always @(negedge clk) begin
    if (vram_sel_o && vram_wr_o) vwr_q.push_back({vram_addr_o, vram_data_o});
    if (vram_sel_o && !vram_wr_o) vrd_q.push_back(vram_addr_o);
    if (font_wr_o) begin
      fadr_q.push_back(font_addr_o);
      fdat_q.push_back(font_data_o);
    end
    if ((vram_sel_o || vram_wr_o) && !blit_cycle_i) bad_sel <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte_i   = b;
    rx_strobe_i = 1'b1;
    tick();
    rx_strobe_i = 1'b0;
    tick();
  endtask

  task automatic frame_end();
    spi_cs_i = 1'b1;
    tick();
    tick();
    spi_cs_i = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy_o && n < 200) begin
      tick();
      n++;
    end
    chk({"idle_", tag}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    logic [15:0] a;
    logic [15:0] w;
    logic [15:0] ea;
    logic [7:0]  b;
    logic        ai;
    int          n;
    logic [31:0] exp_wr[$];
    logic [7:0]  exp_fd[$];

    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[16'h0010] = 16'hBEEF;

    reset = 1'b1; spi_cs_i = 1'b1; rx_strobe_i = 1'b0; rx_byte_i = 8'h00;
    blit_man = 1'b0; blit_rnd_en = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_tx", 32'(tx_byte_o), 32'hFF);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_sel", 32'(vram_sel_o), 32'd0);
    chk("rst_font_wr", 32'(font_wr_o), 32'd0);
    chk("rst_font_addr", 32'(font_addr_o), 32'd0);

    // basic write, slot withheld until the word is complete
    spi_cs_i = 1'b0;
    tick();
    send_byte(8'h00); send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB); send_byte(8'hCD);
    chk("t1_busy_pend", 32'(busy_o), 32'd1);
    chk("t1_no_write_yet", 32'(vwr_q.size()), 32'd0);
    blit_man = 1'b1;
    #1;
    chk("t1_sel", 32'(vram_sel_o), 32'd1);
    chk("t1_wr", 32'(vram_wr_o), 32'd1);
    chk("t1_addr", 32'(vram_addr_o), 32'h1234);
    chk("t1_data", 32'(vram_data_o), 32'hABCD);
    tick();
    blit_man = 1'b0;
    chk("t1_busy_done", 32'(busy_o), 32'd0);
    tick();
    chk("t1_count", 32'(vwr_q.size()), 32'd1);
    frame_end();

    // auto-increment across the 16-bit wrap
    vwr_q.delete();
    blit_man = 1'b1;
    send_byte(8'h01); send_byte(8'hFF); send_byte(8'hFF);
    send_byte(8'h11); send_byte(8'h11); send_byte(8'h22); send_byte(8'h22);
    tick(); tick();
    chk("wrap_count", 32'(vwr_q.size()), 32'd2);
    if (vwr_q.size() == 2) begin
      chk("wrap_w0", vwr_q[0], 32'hFFFF_1111);
      chk("wrap_w1", vwr_q[1], 32'h0000_2222);
    end
    frame_end();
    blit_man = 1'b0;

    // overrun: second word arrives while first still waits for a slot
    vwr_q.delete();
    send_byte(8'h00); send_byte(8'h50); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h11); send_byte(8'h22); send_byte(8'h22);
    chk("ovr_err", 32'(err_o), 32'd1);
    chk("ovr_busy", 32'(busy_o), 32'd1);
    blit_man = 1'b1;
    tick(); tick(); tick();
    blit_man = 1'b0;
    chk("ovr_count", 32'(vwr_q.size()), 32'd1);
    if (vwr_q.size() == 1) chk("ovr_kept", vwr_q[0], 32'h5000_1111);
    chk("ovr_err_sticky", 32'(err_o), 32'd1);
    frame_end();

    // op 2'b11
    send_byte(8'hC0);
`ifdef HOST_CTRL_STATUS_EN
    chk("op3_tx", 32'(tx_byte_o), 32'h01);
`else
    chk("op3_tx", 32'(tx_byte_o), 32'hFF);
`endif
    send_byte(8'hC3);
`ifdef HOST_CTRL_STATUS_EN
    chk("op3_err", 32'(err_o), 32'd0);
`else
    chk("op3_err", 32'(err_o), 32'd1);
`endif
    frame_end();

    // reset while a write is pending
    vwr_q.delete();
    send_byte(8'h00); send_byte(8'h20); send_byte(8'h00); send_byte(8'h55); send_byte(8'h66);
    chk("rstw_busy_pend", 32'(busy_o), 32'd1);
    reset = 1'b1;
    blit_man = 1'b1;
    #1;
    chk("rstw_sel_in_reset", 32'(vram_sel_o), 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick(); tick();
    blit_man = 1'b0;
    chk("rstw_busy", 32'(busy_o), 32'd0);
    chk("rstw_tx", 32'(tx_byte_o), 32'hFF);
    chk("rstw_err", 32'(err_o), 32'd0);
    chk("rstw_no_write", 32'(vwr_q.size()), 32'd0);
    frame_end();

    // directed read with prefetch
    vrd_q.delete();
    blit_man = 1'b1;
    send_byte(8'h41); send_byte(8'h00); send_byte(8'h10);
    wait_idle("rd0");
    tick(); tick();
    chk("rd_hi", 32'(tx_byte_o), 32'hBE);
    send_byte(8'hAA);
    chk("rd_lo", 32'(tx_byte_o), 32'hEF);
    send_byte(8'h55);
    chk("rd_outstanding", 32'(tx_byte_o), 32'hFF);
    wait_idle("rd1");
    tick(); tick();
    chk("rd_count", 32'(vrd_q.size()), 32'd2);
    if (vrd_q.size() == 2) chk("rd_prefetch_addr", 32'(vrd_q[1]), 32'h0011);
    chk("rd_prefetch_hi", 32'(tx_byte_o), 32'(mem[16'h0011][15:8]));
    frame_end();
    blit_man = 1'b0;

    // directed font writes, including the 13-bit wrap
    fadr_q.delete(); fdat_q.delete();
    send_byte(8'h81); send_byte(8'h01); send_byte(8'h00); send_byte(8'h3C); send_byte(8'h42);
    frame_end();
    send_byte(8'h81); send_byte(8'h1F); send_byte(8'hFF); send_byte(8'h11); send_byte(8'h22);
    tick();
    chk("font_count", 32'(fadr_q.size()), 32'd4);
    if (fadr_q.size() == 4) begin
      chk("font0", {fadr_q[0], fdat_q[0]}, {13'h0100, 8'h3C});
      chk("font1", {fadr_q[1], fdat_q[1]}, {13'h0101, 8'h42});
      chk("font_wrap0", {fadr_q[2], fdat_q[2]}, {13'h1FFF, 8'h11});
      chk("font_wrap1", {fadr_q[3], fdat_q[3]}, {13'h0000, 8'h22});
    end
    frame_end();

    // randomized streams with random slot availability
    blit_rnd_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      vwr_q.delete(); exp_wr.delete();
      a  = 16'($urandom);
      ai = (k != 1);
      n  = $urandom_range(2, 5);
      send_byte({7'd0, ai}); send_byte(a[15:8]); send_byte(a[7:0]);
      for (int i = 0; i < n; i++) begin
        w  = 16'($urandom);
        ea = a + 16'(ai ? i : 0);
        exp_wr.push_back({ea, w});
        send_byte(w[15:8]);
        wait_idle($sformatf("rw%0d_%0d", k, i));
        send_byte(w[7:0]);
      end
      wait_idle($sformatf("rw%0d_end", k));
      tick(); tick();
      chk($sformatf("rw%0d_count", k), 32'(vwr_q.size()), 32'(n));
      for (int i = 0; i < n && i < vwr_q.size(); i++)
        chk($sformatf("rw%0d_w%0d", k, i), vwr_q[i], exp_wr[i]);
      chk($sformatf("rw%0d_err", k), 32'(err_o), 32'd0);
      frame_end();
    end

    for (int k = 0; k < 3; k++) begin
      vrd_q.delete();
      a = 16'($urandom);
      n = $urandom_range(2, 4);
      send_byte(8'h41); send_byte(a[15:8]); send_byte(a[7:0]);
      for (int i = 0; i < n; i++) begin
        ea = a + 16'(i);
        wait_idle($sformatf("rr%0d_%0d", k, i));
        tick(); tick();
        chk($sformatf("rr%0d_hi%0d", k, i), 32'(tx_byte_o), 32'(mem[ea][15:8]));
        send_byte(8'($urandom));
        chk($sformatf("rr%0d_lo%0d", k, i), 32'(tx_byte_o), 32'(mem[ea][7:0]));
        send_byte(8'($urandom));
      end
      frame_end();
      wait_idle($sformatf("rr%0d_end", k));
      tick(); tick();
      chk($sformatf("rr%0d_count", k), 32'(vrd_q.size()), 32'(n + 1));
      for (int i = 0; i < vrd_q.size() && i <= n; i++)
        chk($sformatf("rr%0d_a%0d", k, i), 32'(vrd_q[i]), 32'(a + 16'(i)));
    end

    for (int k = 0; k < 3; k++) begin
      fadr_q.delete(); fdat_q.delete(); exp_fd.delete();
      a  = 16'($urandom);
      ai = 1'($urandom_range(0, 1));
      n  = $urandom_range(2, 6);
      send_byte({7'b1000000, ai}); send_byte(a[15:8]); send_byte(a[7:0]);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        exp_fd.push_back(b);
        send_byte(b);
      end
      tick();
      chk($sformatf("rf%0d_count", k), 32'(fadr_q.size()), 32'(n));
      for (int i = 0; i < n && i < fadr_q.size(); i++) begin
        ea = a + 16'(ai ? i : 0);
        chk($sformatf("rf%0d_%0d", k, i), {fadr_q[i], fdat_q[i]}, {ea[12:0], exp_fd[i]});
      end
      frame_end();
    end
    blit_rnd_en = 1'b0;

    chk("sel_only_in_slot", 32'(bad_sel), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
